// File: rtl/ram_march_bist.sv
// March BIST sequencer (W0, R0W1 ascending, R1 descending) for a single-port async-read RAM.
// Optional build macro BIST_STOP_ON_FAIL_EN: end the run on the first mismatch.
module ram_march_bist #(
    parameter int                length    = 2,
    parameter int                locations = 8,
    parameter logic [length-1:0] PATTERN   = length'(1)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_start,
    output logic                                 o_mem_rw,
    output logic [$clog2(locations)-1:0]         o_mem_addr,
    output logic [length-1:0]                    o_mem_wdata,
    input  logic [length-1:0]                    i_mem_rdata,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_pass,
    output logic [$clog2(locations)-1:0]         o_fail_addr,
    output logic [$clog2(2*locations+1)-1:0]     o_fail_count
);

    localparam int AW = $clog2(locations);
    localparam int CW = $clog2(2*locations+1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_W0   = 3'd1;
    localparam logic [2:0] S_R0W1 = 3'd2;
    localparam logic [2:0] S_R1   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [AW-1:0] ADDR_LAST = AW'(locations - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    logic [2:0]        r_state;
    logic [AW-1:0]     r_addr;
    logic              r_wr_half;      // in R0W1: 0 = read cycle, 1 = write cycle
    logic [AW-1:0]     r_fail_addr;
    logic [CW-1:0]     r_fail_count;

    logic              w_rd_cycle;
    logic [length-1:0] w_expect;
    logic [length-1:0] w_diff;
    logic              w_mismatch;
    logic              w_first_fail;

    assign w_rd_cycle = ((r_state == S_R0W1) && !r_wr_half) || (r_state == S_R1);
    assign w_expect   = (r_state == S_R1) ? ~PATTERN : PATTERN;

    genvar gi;
    generate
        for (gi = 0; gi < length; gi++) begin : g_cmp
            assign w_diff[gi] = i_mem_rdata[gi] ^ w_expect[gi];
        end
    endgenerate

    assign w_mismatch   = w_rd_cycle && (|w_diff);
    assign w_first_fail = w_mismatch && (r_fail_count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_wr_half    <= 1'b0;
            r_fail_addr  <= '0;
            r_fail_count <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state      <= S_W0;
                        r_addr       <= '0;
                        r_wr_half    <= 1'b0;
                        r_fail_addr  <= '0;
                        r_fail_count <= '0;
                    end
                end
                S_W0: begin
                    if (r_addr == ADDR_LAST) begin
                        r_state <= S_R0W1;
                        r_addr  <= '0;
                    end else begin
                        r_addr <= r_addr + AW'(1);
                    end
                end
                S_R0W1: begin
                    if (!r_wr_half) begin
                        r_wr_half <= 1'b1;
                    end else begin
                        r_wr_half <= 1'b0;
                        if (r_addr == ADDR_LAST) begin
                            r_state <= S_R1;
                            r_addr  <= ADDR_LAST;
                        end else begin
                            r_addr <= r_addr + AW'(1);
                        end
                    end
                end
                S_R1: begin
                    if (r_addr == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_addr <= r_addr - AW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Mismatch bookkeeping overrides the sequencing above where they overlap.
            if (w_mismatch) begin
                if (r_fail_count != CNT_MAX) begin
                    r_fail_count <= r_fail_count + CW'(1);
                end
                if (w_first_fail) begin
                    r_fail_addr <= r_addr;
                end
            end
`ifdef BIST_STOP_ON_FAIL_EN
            if (w_first_fail) begin
                r_state   <= S_DONE;
                r_addr    <= '0;
                r_wr_half <= 1'b0;
            end
`endif
        end
    end

    // Outputs decode directly from state so reset silences the RAM interface at once.
    always_comb begin
        o_mem_rw    = 1'b0;
        o_mem_wdata = '0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            S_W0: begin
                o_busy      = 1'b1;
                o_mem_rw    = 1'b1;
                o_mem_wdata = PATTERN;
            end
            S_R0W1: begin
                o_busy = 1'b1;
                if (r_wr_half) begin
                    o_mem_rw    = 1'b1;
                    o_mem_wdata = ~PATTERN;
                end
            end
            S_R1: begin
                o_busy = 1'b1;
            end
            S_DONE: begin
                o_done = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

    assign o_mem_addr   = o_busy ? r_addr : '0;
    assign o_pass       = o_done && (r_fail_count == '0);
    assign o_fail_addr  = r_fail_addr;
    assign o_fail_count = r_fail_count;

endmodule

// File: tb/tb_ram_march_bist.sv
// Self-checking bench for ram_march_bist: faulty-RAM model, march reference model, cycle-exact trace checks.
module tb_ram_march_bist;

    localparam int         L  = 8;
    localparam int         W  = 2;
    localparam int         AW = 3;
    localparam int         CW = 5;
    localparam logic [1:0] P  = 2'b01;
    localparam logic [1:0] PN = 2'b10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_start;
    logic          o_mem_rw;
    logic [AW-1:0] o_mem_addr;
    logic [W-1:0]  o_mem_wdata;
    logic [W-1:0]  i_mem_rdata;
    logic          o_busy;
    logic          o_done;
    logic          o_pass;
    logic [AW-1:0] o_fail_addr;
    logic [CW-1:0] o_fail_count;

    int n_checks = 0;
    int n_fail   = 0;

    // RAM model with per-address stuck-at masks applied on read
    logic [W-1:0] ram [L];
    logic [W-1:0] sa0 [L];
    logic [W-1:0] sa1 [L];

    ram_march_bist #(.length(W), .locations(L), .PATTERN(P)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .o_mem_rw     (o_mem_rw),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_rdata  (i_mem_rdata),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_pass       (o_pass),
        .o_fail_addr  (o_fail_addr),
        .o_fail_count (o_fail_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_mem_rw) ram[o_mem_addr] <= o_mem_wdata;
    end

    assign i_mem_rdata = (ram[o_mem_addr] & ~sa0[o_mem_addr]) | sa1[o_mem_addr];

    typedef struct {
        bit rw;
        int addr;
        int wdata;
    } op_t;

    op_t exp_ops[$];
    int  exp_count;
    int  exp_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_faults();
        for (int a = 0; a < L; a++) begin
            sa0[a] = '0;
            sa1[a] = '0;
        end
    endtask

    // Reference: the march algorithm as plain loops over a word array.
    task automatic build_model();
        logic [1:0] m [L];
        logic [1:0] rd;
        bit         stop;
        op_t        o;
        exp_ops.delete();
        exp_count = 0;
        exp_addr  = 0;
        stop      = 0;
        for (int a = 0; a < L; a++) begin
            o.rw = 1; o.addr = a; o.wdata = int'(P);
            exp_ops.push_back(o);
            m[a] = P;
        end
        for (int a = 0; a < L && !stop; a++) begin
            o.rw = 0; o.addr = a; o.wdata = 0;
            exp_ops.push_back(o);
            rd = (m[a] & ~sa0[a]) | sa1[a];
            if (rd != P) begin
                exp_count++;
                if (exp_count == 1) exp_addr = a;
`ifdef BIST_STOP_ON_FAIL_EN
                stop = 1;
`endif
            end
            if (!stop) begin
                o.rw = 1; o.addr = a; o.wdata = int'(PN);
                exp_ops.push_back(o);
                m[a] = PN;
            end
        end
        for (int a = L - 1; a >= 0 && !stop; a--) begin
            o.rw = 0; o.addr = a; o.wdata = 0;
            exp_ops.push_back(o);
            rd = (m[a] & ~sa0[a]) | sa1[a];
            if (rd != PN) begin
                exp_count++;
                if (exp_count == 1) exp_addr = a;
`ifdef BIST_STOP_ON_FAIL_EN
                stop = 1;
`endif
            end
        end
        if (exp_count > (1 << CW) - 1) exp_count = (1 << CW) - 1;
    endtask

    // One full run: pulse (or hold) start, compare every test cycle, then the DONE results.
    task automatic run_march(input string name, input bit hold, input bit noise);
        build_model();
        @(negedge clk) i_start = 1'b1;
        @(negedge clk) if (!hold) i_start = 1'b0;
        for (int k = 0; k < exp_ops.size(); k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("%s_c%0d_rw", name, k), 32'(o_mem_rw), 32'(exp_ops[k].rw));
            check($sformatf("%s_c%0d_addr", name, k), 32'(o_mem_addr), 32'(exp_ops[k].addr));
            check($sformatf("%s_c%0d_wdata", name, k), 32'(o_mem_wdata), 32'(exp_ops[k].wdata));
            check($sformatf("%s_c%0d_busy", name, k), 32'(o_busy), 32'd1);
            check($sformatf("%s_c%0d_done", name, k), 32'(o_done), 32'd0);
            if (!hold && noise) i_start = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        i_start = hold;
        check({name, "_done"}, 32'(o_done), 32'd1);
        check({name, "_busy"}, 32'(o_busy), 32'd0);
        check({name, "_pass"}, 32'(o_pass), 32'(exp_count == 0));
        check({name, "_fcount"}, 32'(o_fail_count), 32'(exp_count));
        check({name, "_faddr"}, 32'(o_fail_addr), 32'(exp_addr));
        check({name, "_rw_idle"}, 32'(o_mem_rw), 32'd0);
        check({name, "_addr_idle"}, 32'(o_mem_addr), 32'd0);
        $display("run %s: %0d cycles, pass=%0d fail_count=%0d fail_addr=%0d (expected %0d/%0d/%0d)",
                 name, exp_ops.size(), o_pass, o_fail_count, o_fail_addr,
                 exp_count == 0, exp_count, exp_addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        i_start = 1'b0;
        clear_faults();
        #12;
        check("rst_rw", 32'(o_mem_rw), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_pass", 32'(o_pass), 32'd0);
        check("rst_fcount", 32'(o_fail_count), 32'd0);
        check("rst_faddr", 32'(o_fail_addr), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(o_busy), 32'd0);

        run_march("clean", 0, 0);

        sa0[5] = 2'b01;
        run_march("sa0_a5b0", 0, 0);

        clear_faults();
        sa1[2] = 2'b10;
        run_march("sa1_a2b1", 0, 0);

        // start held high: DONE lasts one cycle, then a fresh run with cleared counters
        run_march("hold", 1, 0);
        @(negedge clk);
        check("hold_restart_busy", 32'(o_busy), 32'd1);
        check("hold_restart_done", 32'(o_done), 32'd0);
        check("hold_restart_fcount", 32'(o_fail_count), 32'd0);
        check("hold_restart_faddr", 32'(o_fail_addr), 32'd0);
        check("hold_restart_rw", 32'(o_mem_rw), 32'd1);
        i_start = 1'b0;
        for (int i = 0; i < 4 * L + 4 && !o_done; i++) @(negedge clk);
        check("hold_rerun_done", 32'(o_done), 32'd1);
        check("hold_rerun_fcount", 32'(o_fail_count), 32'(exp_count));
        $display("run hold_rerun: done=%0d fail_count=%0d", o_done, o_fail_count);

        // reset asserted mid-run during the R0W1 write cycle of address 2
        clear_faults();
        @(negedge clk) i_start = 1'b1;
        @(negedge clk) i_start = 1'b0;
        repeat (13) @(negedge clk);
        check("rstmid_pre_rw", 32'(o_mem_rw), 32'd1);
        check("rstmid_pre_addr", 32'(o_mem_addr), 32'd2);
        rst_n = 1'b0;
        #1;
        check("rstmid_rw", 32'(o_mem_rw), 32'd0);
        check("rstmid_busy", 32'(o_busy), 32'd0);
        check("rstmid_done", 32'(o_done), 32'd0);
        check("rstmid_wdata", 32'(o_mem_wdata), 32'd0);
        @(posedge clk) #1;
        check("rstmid_no_write", 32'(ram[2]), 32'(P));
        @(negedge clk) rst_n = 1'b1;
        $display("run reset_mid: abandoned at test cycle 13");
        run_march("after_rst", 0, 0);

        for (int it = 0; it < 10; it++) begin
            int nf;
            clear_faults();
            nf = $urandom_range(0, 2);
            for (int f = 0; f < nf; f++) begin
                int a;
                logic [1:0] b;
                a = $urandom_range(0, L - 1);
                b = 2'b01 << $urandom_range(0, 1);
                if ($urandom_range(0, 1) == 1) sa0[a] = sa0[a] | b;
                else                           sa1[a] = sa1[a] | b;
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_march($sformatf("rand%0d", it), 0, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
